// File: rtl/i2s_stereo_tx_if.sv
// ----------------------------------------------------------------------------
// i2s_stereo_tx_if
// Sample handshake between a stereo sample source and i2s_stereo_tx.
//   sample_l / sample_r : left / right sample, two's complement (DATA_W bits)
//   sample_valid        : source offers {sample_l, sample_r}
//   sample_ready        : transmitter holding buffer is empty
// Modports: master = sample source, slave = transmitter.
// ----------------------------------------------------------------------------
interface i2s_stereo_tx_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] sample_l;
    logic [DATA_W-1:0] sample_r;
    logic              sample_valid;
    logic              sample_ready;

    modport master (
        output sample_l,
        output sample_r,
        output sample_valid,
        input  sample_ready
    );

    modport slave (
        input  sample_l,
        input  sample_r,
        input  sample_valid,
        output sample_ready
    );
endinterface

// File: rtl/i2s_stereo_tx.sv
// ----------------------------------------------------------------------------
// i2s_stereo_tx
// I2S stereo transmitter for the WM8731 codec path. Takes independent
// left/right samples through a one-entry holding buffer and serializes them
// MSB first into SLOT_W-bit slots, with bclk derived from clk by CLK_DIV.
//
// Parameters:
//   DATA_W  : sample width per channel (8..32)
//   SLOT_W  : bclk periods per channel slot (>= DATA_W), LSB padding is 0
//   CLK_DIV : clk cycles per bclk half-period (>= 1)
//
// Ports:
//   i_clk      : system clock, posedge
//   i_reset    : synchronous active-high reset (also empties the buffer)
//   i_enable   : 1 = serializer runs, 0 = serializer held idle
//   s_if       : sample handshake (slave modport)
//   o_bclk     : bit clock to codec
//   o_ws       : word select, 0 = left, 1 = right
//   o_sd       : serial data, changes on bclk falling events
//   o_underrun : one-clk pulse when a frame starts with the buffer empty
//
// Configuration macro I2S_STEREO_TX_LJ_EN: when defined, ws follows the
// left-justified format (high exactly for the right slot, no one-bit lead).
// ----------------------------------------------------------------------------
module i2s_stereo_tx #(
    parameter int DATA_W  = 16,
    parameter int SLOT_W  = 16,
    parameter int CLK_DIV = 8
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic           i_enable,
    i2s_stereo_tx_if.slave s_if,
    output logic           o_bclk,
    output logic           o_ws,
    output logic           o_sd,
    output logic           o_underrun
);
    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = $clog2(CLK_DIV) + 1;
    localparam int K_W     = $clog2(FRAME_W);
    localparam int PAD_W   = SLOT_W - DATA_W;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_W - 1);

    logic [DIV_W-1:0]   r_div_cnt;
    logic               r_bclk;
    logic               r_ws;
    logic               r_underrun;
    logic [K_W-1:0]     r_k;
    logic [FRAME_W-1:0] r_shreg;
    logic               r_full;
    logic [DATA_W-1:0]  r_buf_l;
    logic [DATA_W-1:0]  r_buf_r;

    logic               w_wrap;
    logic               w_fall;
    logic               w_load;
    logic               w_accept;
    logic               w_ws_next;
    logic [K_W-1:0]     w_k_next;
    logic [SLOT_W-1:0]  w_slot_l;
    logic [SLOT_W-1:0]  w_slot_r;

    assign w_wrap   = (r_div_cnt == DIV_LAST);
    // Falling event: the edge where bclk goes 1->0. Everything on the codec
    // side (sd, ws, k) moves only here so sd is stable at the bclk rise.
    assign w_fall   = i_enable && w_wrap && r_bclk;
    assign w_k_next = (r_k == K_LAST) ? '0 : r_k + 1'b1;
    assign w_load   = w_fall && (r_k == K_LAST);
    assign w_accept = s_if.sample_valid && !r_full;

    // Slot = sample left-aligned, zero padded below.
    assign w_slot_l = SLOT_W'(r_buf_l) << PAD_W;
    assign w_slot_r = SLOT_W'(r_buf_r) << PAD_W;

    // ws is computed for the bit index being entered, and registered on the
    // same falling event, so it lines up with the sd bit it describes.
`ifdef I2S_STEREO_TX_LJ_EN
    assign w_ws_next = (int'(w_k_next) >= SLOT_W);
`else
    assign w_ws_next = (int'(w_k_next) >= SLOT_W - 1) &&
                       (int'(w_k_next) <= FRAME_W - 2);
`endif

    // Serializer: divider, bit index, ws and shift register.
    always_ff @(posedge i_clk) begin
        if (i_reset || !i_enable) begin
            r_div_cnt  <= '0;
            r_bclk     <= 1'b0;
            r_ws       <= 1'b0;
            r_k        <= K_LAST;
            r_shreg    <= '0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            if (w_wrap) begin
                r_div_cnt <= '0;
                r_bclk    <= ~r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_fall) begin
                r_k  <= w_k_next;
                r_ws <= w_ws_next;
                if (w_load) begin
                    // Empty buffer at the frame boundary sends silence.
                    r_shreg    <= r_full ? {w_slot_l, w_slot_r} : '0;
                    r_underrun <= !r_full;
                end else begin
                    r_shreg <= {r_shreg[FRAME_W-2:0], 1'b0};
                end
            end
        end
    end

    // Holding buffer. Runs regardless of i_enable. A load in the same clk
    // as an accept sees the old (empty) state, so there is no bypass.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_full  <= 1'b0;
            r_buf_l <= '0;
            r_buf_r <= '0;
        end else if (w_accept) begin
            r_full  <= 1'b1;
            r_buf_l <= s_if.sample_l;
            r_buf_r <= s_if.sample_r;
        end else if (w_load) begin
            r_full  <= 1'b0;
        end
    end

    assign s_if.sample_ready = !r_full;
    assign o_bclk            = r_bclk;
    assign o_ws              = r_ws;
    assign o_sd              = r_shreg[FRAME_W-1];
    assign o_underrun        = r_underrun;
endmodule

// File: tb/tb_i2s_stereo_tx.sv
// ----------------------------------------------------------------------------
// tb_i2s_stereo_tx
// Directed bench for i2s_stereo_tx. DUT1: DATA_W=16, SLOT_W=16, CLK_DIV=2
// (frame = 128 clk, bit k sampled at load+2+4k). DUT2: SLOT_W=24 for the
// padding case. All sampling and driving happens at clk negedges.
// ----------------------------------------------------------------------------
module tb_i2s_stereo_tx;
    logic clk = 1'b0;
    logic reset, enable, en2;
    always #5 clk = ~clk;

    i2s_stereo_tx_if #(.DATA_W(16)) if1 ();
    i2s_stereo_tx_if #(.DATA_W(16)) if2 ();

    logic bclk1, ws1, sd1, uf1;
    logic bclk2, ws2, sd2, uf2;

    i2s_stereo_tx #(.DATA_W(16), .SLOT_W(16), .CLK_DIV(2)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .s_if(if1),
        .o_bclk(bclk1), .o_ws(ws1), .o_sd(sd1), .o_underrun(uf1));

    i2s_stereo_tx #(.DATA_W(16), .SLOT_W(24), .CLK_DIV(2)) dut2 (
        .i_clk(clk), .i_reset(reset), .i_enable(en2), .s_if(if2),
        .o_bclk(bclk2), .o_ws(ws2), .o_sd(sd2), .o_underrun(uf2));

`ifdef I2S_STEREO_TX_LJ_EN
    localparam logic [31:0] WS16 = 32'h0000_FFFF;
    localparam logic [47:0] WS24 = 48'h0000_00FF_FFFF;
`else
    localparam logic [31:0] WS16 = 32'h0001_FFFE;
    localparam logic [47:0] WS24 = 48'h0000_01FF_FFFE;
`endif

    int checks = 0;
    int errors = 0;
    int uf_cnt, acc_cnt, bp_n, u0;
    logic bp, rel, done2;
    logic [31:0] sdw, wsw;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Advance n clocks; tracks underrun pulses and, in backpressure mode,
    // presents a fresh sample after each accept.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            logic pend;
            pend = bp && if1.sample_valid && if1.sample_ready;
            @(negedge clk);
            if (pend) begin
                acc_cnt++;
                bp_n++;
                if1.sample_l = 16'h1000 + 16'(bp_n);
                if1.sample_r = 16'h2000 + 16'(bp_n);
            end
            if (uf1) uf_cnt++;
        end
    endtask

    // Called at load+2; ends at load+126.
    task automatic cap(output logic [31:0] s, output logic [31:0] w);
        for (int k = 0; k < 32; k++) begin
            if (k > 0) tick(4);
            s[31-k] = sd1;
            w[31-k] = ws1;
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; en2 = 1'b1;
        bp = 1'b0; rel = 1'b0; bp_n = 0; acc_cnt = 0; uf_cnt = 0; u0 = 0;
        if1.sample_valid = 1'b0; if1.sample_l = '0; if1.sample_r = '0;
        if2.sample_valid = 1'b0; if2.sample_l = '0; if2.sample_r = '0;
        tick(3);
        chk("rst_bclk", bclk1, 1'b0);
        chk("rst_ws", ws1, 1'b0);
        chk("rst_sd", sd1, 1'b0);
        chk("rst_uf", uf1, 1'b0);
        chk("rst_rdy", if1.sample_ready, 1'b1);
        chk("rst_dut2", {bclk2, ws2, sd2, uf2, if2.sample_ready}, 5'b00001);
        reset = 1'b0; rel = 1'b1;

        tick(3);                                   // clk 3
        chk("c3_bclk", bclk1, 1'b1);
        chk("c3_uf", uf1, 1'b0);
        tick(1);                                   // clk 4: first load, empty
        chk("c4_uf", uf1, 1'b1);
        chk("c4_bclk", bclk1, 1'b0);
        chk("c4_sd", sd1, 1'b0);
        chk("c4_rdy", if1.sample_ready, 1'b1);
        if1.sample_l = 16'hA5C3; if1.sample_r = 16'h0F0F; if1.sample_valid = 1'b1;
        tick(1);                                   // clk 5: accepted
        if1.sample_valid = 1'b0;
        chk("c5_uf", uf1, 1'b0);
        chk("c5_rdy", if1.sample_ready, 1'b0);
        tick(1);
        cap(sdw, wsw);                             // silence frame
        chk("f1_sd", sdw, 32'h0);
        chk("f1_ws", wsw, WS16);
        u0 = uf_cnt;
        tick(1);                                   // clk 131
        chk("f2_rdy_pre", if1.sample_ready, 1'b0);
        tick(1);                                   // clk 132: load A5C3/0F0F
        chk("f2_rdy_post", if1.sample_ready, 1'b1);
        tick(2);
        cap(sdw, wsw);
        chk("f2_sd", sdw, 32'hA5C3_0F0F);
        chk("f2_ws", wsw, WS16);
        chk("f2_no_uf", uf_cnt - u0, 0);
        tick(2);                                   // clk 260: empty again
        chk("f3_uf", uf1, 1'b1);

        // Accept coincident with a load: underrun, sample goes a frame later.
        tick(127);                                 // clk 387
        if1.sample_l = 16'h1234; if1.sample_r = 16'hABCD; if1.sample_valid = 1'b1;
        tick(1);                                   // clk 388
        if1.sample_valid = 1'b0;
        chk("sc_uf", uf1, 1'b1);
        chk("sc_rdy", if1.sample_ready, 1'b0);
        tick(2);
        cap(sdw, wsw);
        chk("sc_f1_sd", sdw, 32'h0);
        tick(4);
        cap(sdw, wsw);
        chk("sc_f2_sd", sdw, 32'h1234_ABCD);
        tick(2);                                   // clk 644
        chk("sc_end_uf", uf1, 1'b1);

        // Backpressure: valid held, new sample after each accept.
        u0 = uf_cnt; bp_n = 0; acc_cnt = 0; bp = 1'b1;
        if1.sample_l = 16'h1000; if1.sample_r = 16'h2000; if1.sample_valid = 1'b1;
        tick(130);                                 // clk 774
        for (int f = 0; f < 8; f++) begin
            if (f > 0) tick(4);
            cap(sdw, wsw);
            chk("bp_sd", sdw, {16'h1000 + 16'(f), 16'h2000 + 16'(f)});
        end                                        // clk 1794
        chk("bp_acc", acc_cnt, 9);
        chk("bp_uf", uf_cnt - u0, 0);
        if1.sample_valid = 1'b0; bp = 1'b0;

        // enable low mid-frame with a sample pending.
        tick(2);                                   // clk 1796: loads sample 8
        chk("en_rdy_load", if1.sample_ready, 1'b1);
        u0 = uf_cnt;
        if1.sample_l = 16'hC0DE; if1.sample_r = 16'hBEEF; if1.sample_valid = 1'b1;
        tick(1);
        if1.sample_valid = 1'b0;
        chk("en_rdy_acc", if1.sample_ready, 1'b0);
        tick(23);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("en_idle", {bclk1, ws1, sd1, uf1}, 4'b0000);
        end
        chk("en_hold", if1.sample_ready, 1'b0);
        enable = 1'b1;
        tick(4);                                   // restart load
        chk("en_load_rdy", if1.sample_ready, 1'b1);
        tick(2);
        cap(sdw, wsw);
        chk("en_sd", sdw, 32'hC0DE_BEEF);
        chk("en_ws", wsw, WS16);
        chk("en_uf", uf_cnt - u0, 0);

        for (int i = 0; i < 1000 && !done2; i++) @(negedge clk);
        chk("dut2_done", done2, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // DUT2 padding case: first load clk 4, next at clk 196 (frame = 192 clk).
    initial begin : p2
        logic [47:0] s2, w2;
        done2 = 1'b0;
        s2 = '0; w2 = '0;
        wait (rel);
        repeat (4) @(negedge clk);
        chk("p2_uf", uf2, 1'b1);
        if2.sample_l = 16'h8001; if2.sample_r = 16'h7FFE; if2.sample_valid = 1'b1;
        @(negedge clk);
        if2.sample_valid = 1'b0;
        repeat (193) @(negedge clk);               // clk 198
        for (int k = 0; k < 48; k++) begin
            if (k > 0) repeat (4) @(negedge clk);
            s2[47-k] = sd2;
            w2[47-k] = ws2;
        end
        chk("p2_sd", s2, 48'h8001_00_7FFE_00);
        chk("p2_ws", w2, WS24);
        done2 = 1'b1;
    end
endmodule
